gmm_vmm_stream_ctrl: RTL and testbench

Streaming front/back end for the serial-parallel complex vector-matrix multiplier.
- Accepts mean-difference samples on a valid/ready input and drives the multiplier's s_r/s_i and ce.
- Tracks each accepted sample through the multiplier latency with a tag pipeline, captures the matching y_r/y_i, and buffers results in a FIFO behind a valid/ready output.
- Uses credit-based ce gating so results are never dropped under output back-pressure.

---
 rtl/gmm_vmm_stream_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_gmm_vmm_stream_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmm_vmm_stream_ctrl.sv
// ---------------------------------------------------------------------------
// gmm_vmm_stream_ctrl
//
// Streaming front/back end for the serial-parallel complex vector-matrix
// multiplier. Input samples go to the multiplier (mult_s_*, mult_ce). A tag
// pipeline follows each sample through the multiplier latency. When the
// result comes back on y_*, it is captured into a result FIFO that drives a
// valid/ready output. The multiplier clock enable is credit-gated, so a
// result that has been started always has a free FIFO slot to land in.
//
// Parameters:
//   D_WIDTH    width of one real/imag input component (results 2*D_WIDTH)
//   PIPE_DEPTH ce-cycles from sample on mult_s_* to its result on y_* (>=1)
//   FIFO_DEPTH result FIFO entries, power of two, >= PIPE_DEPTH+1
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   clear                synchronous flush of tags and FIFO
//   s_valid/s_ready      input sample handshake, s_r/s_i/s_last payload
//   mult_ce              multiplier clock enable
//   mult_s_r/mult_s_i    sample to multiplier (zero on bubbles)
//   y_r/y_i              multiplier result
//   m_valid/m_ready      result handshake, m_y_r/m_y_i/m_last payload
//   busy                 tags in flight or FIFO non-empty
//   res_cnt/frm_cnt      results / frames emitted
//
// Optional feature macro: GMM_VMM_CNT_EN
//   defined   -> res_cnt/frm_cnt count pops / pops with m_last
//   undefined -> res_cnt/frm_cnt tied to 0
// ---------------------------------------------------------------------------
module gmm_vmm_stream_ctrl #(
  parameter int D_WIDTH    = 16,
  parameter int PIPE_DEPTH = 7,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [D_WIDTH-1:0]     s_r,
  input  logic [D_WIDTH-1:0]     s_i,
  input  logic                   s_last,
  output logic                   mult_ce,
  output logic [D_WIDTH-1:0]     mult_s_r,
  output logic [D_WIDTH-1:0]     mult_s_i,
  input  logic [2*D_WIDTH-1:0]   y_r,
  input  logic [2*D_WIDTH-1:0]   y_i,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*D_WIDTH-1:0]   m_y_r,
  output logic [2*D_WIDTH-1:0]   m_y_i,
  output logic                   m_last,
  output logic                   busy,
  output logic [31:0]            res_cnt,
  output logic [31:0]            frm_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(PIPE_DEPTH + 1);
  localparam int ENT_W = 4 * D_WIDTH + 1;

  logic                  run_q;
  logic [PIPE_DEPTH-1:0] tagValid_q, tagValid_d;
  logic [PIPE_DEPTH-1:0] tagLast_q, tagLast_d;
  logic [INF_W-1:0]      inflight_q, inflight_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [ENT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]      head;
  logic [31:0]           credUsed;
  logic                  accept;
  logic                  capture;
  logic                  pop;

  // Every sample in flight already owns a FIFO slot, so ce only runs while
  // there is room for one more. run_q holds ce low while reset is asserted
  // and for the first edge after release.
  assign credUsed = 32'(occ_q) + 32'(inflight_q);
  assign mult_ce  = run_q & ~clear & (credUsed < 32'(FIFO_DEPTH));
  assign s_ready  = mult_ce;

  assign accept  = s_valid & mult_ce;
  assign capture = mult_ce & tagValid_q[PIPE_DEPTH-1];
  assign pop     = m_valid & m_ready;

  // Idle cycles present zero. These bubbles keep the multiplier draining.
  assign mult_s_r = accept ? s_r : '0;
  assign mult_s_i = accept ? s_i : '0;

  always_comb begin
    tagValid_d = tagValid_q;
    tagLast_d  = tagLast_q;
    inflight_d = inflight_q;
    occ_d      = occ_q;
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;

    if (mult_ce) begin
      tagValid_d[0] = accept;
      tagLast_d[0]  = accept & s_last;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        tagValid_d[k] = tagValid_q[k-1];
        tagLast_d[k]  = tagLast_q[k-1];
      end
    end

    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + INF_W'(1);
      2'b01:   inflight_d = inflight_q - INF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({capture, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (capture) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (pop)     rdPtr_d = rdPtr_q + PTR_W'(1);

    // Flush drops every in-flight tag and all buffered results. Results that
    // are still inside the multiplier then return with invalid tags and are
    // ignored.
    if (clear) begin
      tagValid_d = '0;
      tagLast_d  = '0;
      inflight_d = '0;
      occ_d      = '0;
      wrPtr_d    = '0;
      rdPtr_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      tagValid_q <= '0;
      tagLast_q  <= '0;
      inflight_q <= '0;
      occ_q      <= '0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
    end else begin
      run_q      <= 1'b1;
      tagValid_q <= tagValid_d;
      tagLast_q  <= tagLast_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
    end
  end

  // Result storage has no reset. Outputs are masked while the FIFO is empty,
  // so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wrPtr_q] <= {y_r, y_i, tagLast_q[PIPE_DEPTH-1]};
    end
  end

  assign head    = mem_q[rdPtr_q];
  assign m_valid = (occ_q != '0);
  assign m_y_r   = m_valid ? head[ENT_W-1 -: 2*D_WIDTH] : '0;
  assign m_y_i   = m_valid ? head[2*D_WIDTH -: 2*D_WIDTH] : '0;
  assign m_last  = m_valid & head[0];
  assign busy    = (inflight_q != '0) | (occ_q != '0);

`ifdef GMM_VMM_CNT_EN
  logic [31:0] resCnt_q;
  logic [31:0] frmCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resCnt_q <= '0;
      frmCnt_q <= '0;
    end else if (pop) begin
      resCnt_q <= resCnt_q + 32'd1;
      if (m_last) frmCnt_q <= frmCnt_q + 32'd1;
    end
  end

  assign res_cnt = resCnt_q;
  assign frm_cnt = frmCnt_q;
`else
  assign res_cnt = '0;
  assign frm_cnt = '0;
`endif

endmodule

// File: tb/tb_gmm_vmm_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for gmm_vmm_stream_ctrl.
//
// The multiplier stub is a PIPE_DEPTH-stage ce-gated delay line. It returns
// y_r = {C0DE, s_r} and y_i = {s_i, BEEF}, so every emitted result can be
// traced back to the sample that produced it. Sample n of a stream carries
// values derived from n and a per-stream base. s_last is set on every 4th
// sample.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gmm_vmm_stream_ctrl;

  localparam int DW = 16;
  localparam int PD = 7;
  localparam int FD = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_last = 1'b0;
  logic            m_ready = 1'b0;
  logic [DW-1:0]   s_r = '0;
  logic [DW-1:0]   s_i = '0;
  logic            s_ready, mult_ce, m_valid, m_last, busy;
  logic [DW-1:0]   mult_s_r, mult_s_i;
  logic [2*DW-1:0] y_r, y_i, m_y_r, m_y_i;
  logic [31:0]     res_cnt, frm_cnt;

  logic [DW-1:0]   stubR [PD];
  logic [DW-1:0]   stubI [PD];

  int errors = 0;
  int checks = 0;
  int inIdx, outIdx, inTotal, valBase, cyc;
  int firstAccCyc, firstValCyc, maxOutstanding;
  int popTotal, frmTotal, guard;
  logic [31:0] expRes, expFrm;

  gmm_vmm_stream_ctrl #(.D_WIDTH(DW), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i), .s_last(s_last),
    .mult_ce(mult_ce), .mult_s_r(mult_s_r), .mult_s_i(mult_s_i),
    .y_r(y_r), .y_i(y_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_y_r(m_y_r), .m_y_i(m_y_i),
    .m_last(m_last), .busy(busy), .res_cnt(res_cnt), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  // Multiplier stub: holds while ce is low, shifts on ce.
  always @(posedge clk) begin
    if (mult_ce) begin
      stubR[0] <= mult_s_r;
      stubI[0] <= mult_s_i;
      for (int k = 1; k < PD; k++) begin
        stubR[k] <= stubR[k-1];
        stubI[k] <= stubI[k-1];
      end
    end
  end

  assign y_r = {16'hC0DE, stubR[PD-1]};
  assign y_i = {stubI[PD-1], 16'hBEEF};

  function automatic logic [DW-1:0] sampR(input int n);
    return DW'(valBase + n * 3 + 1);
  endfunction

  function automatic logic [DW-1:0] sampI(input int n);
    return DW'(16'h4000 + valBase + n * 5);
  endfunction

  function automatic logic [31:0] expYr(input int n);
    return {16'hC0DE, sampR(n)};
  endfunction

  function automatic logic [31:0] expYi(input int n);
    return {sampI(n), 16'hBEEF};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startStream(input int total, input int base);
    inIdx          = 0;
    outIdx         = 0;
    inTotal        = total;
    valBase        = base;
    firstAccCyc    = -1;
    firstValCyc    = -1;
    maxOutstanding = 0;
  endtask

  // One clock cycle. Inputs are driven at the falling edge. Handshakes and
  // popped data are evaluated 1ns later, well away from the rising edge.
  task automatic applyStimulus(input logic mr, input logic clr);
    @(negedge clk);
    m_ready = mr;
    clear   = clr;
    if (inIdx < inTotal) begin
      s_valid = 1'b1;
      s_r     = sampR(inIdx);
      s_i     = sampI(inIdx);
      s_last  = (inIdx % 4 == 3);
    end else begin
      s_valid = 1'b0;
      s_r     = '0;
      s_i     = '0;
      s_last  = 1'b0;
    end
    #1;
    if (s_valid && s_ready) begin
      if (firstAccCyc < 0) firstAccCyc = cyc;
      inIdx++;
    end
    if (m_valid && firstValCyc < 0) firstValCyc = cyc;
    if (m_valid && m_ready) begin
      checkOutput("data_r", m_y_r, expYr(outIdx));
      checkOutput("data_i", m_y_i, expYi(outIdx));
      checkOutput("last", 32'(m_last), 32'(outIdx % 4 == 3));
      popTotal++;
      if (outIdx % 4 == 3) frmTotal++;
      outIdx++;
    end
    if (inIdx - outIdx > maxOutstanding) maxOutstanding = inIdx - outIdx;
    cyc++;
  endtask

  initial begin
    popTotal = 0;
    frmTotal = 0;
    cyc      = 0;
    startStream(0, 0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_ce", 32'(mult_ce), 32'd0);
    checkOutput("rst_sready", 32'(s_ready), 32'd0);
    checkOutput("rst_mvalid", 32'(m_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_myr", m_y_r, 32'd0);
    checkOutput("rst_mlast", 32'(m_last), 32'd0);
    checkOutput("rst_rescnt", res_cnt, 32'd0);
    checkOutput("rst_frmcnt", frm_cnt, 32'd0);
    rst_n = 1'b1;

    // Idle after release: bubbles only, nothing written into the FIFO
    repeat (12) applyStimulus(1'b1, 1'b0);
    checkOutput("idle_ce", 32'(mult_ce), 32'd1);
    checkOutput("idle_sready", 32'(s_ready), 32'd1);
    checkOutput("idle_mvalid", 32'(m_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Four-sample frame, no back-pressure
    startStream(4, 0);
    guard = 0;
    while (outIdx < inTotal && guard < 60) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    checkOutput("t2_count", 32'(outIdx), 32'd4);
    checkOutput("t2_latency", 32'(firstValCyc - firstAccCyc), 32'd8);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_busy", 32'(busy), 32'd0);

    // Full back-pressure: exactly FIFO_DEPTH samples are accepted
    startStream(20, 100);
    repeat (30) applyStimulus(1'b0, 1'b0);
    checkOutput("t3_accepted", 32'(inIdx), 32'd16);
    checkOutput("t3_sready", 32'(s_ready), 32'd0);
    checkOutput("t3_ce", 32'(mult_ce), 32'd0);
    checkOutput("t3_mvalid", 32'(m_valid), 32'd1);
    guard = 0;
    while (outIdx < inTotal && guard < 200) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    repeat (5) applyStimulus(1'b1, 1'b0);
    checkOutput("t3_count", 32'(outIdx), 32'd20);
    checkOutput("t3_mvalid_end", 32'(m_valid), 32'd0);
    checkOutput("t3_busy_end", 32'(busy), 32'd0);

    // m_ready toggling every cycle over a 40-sample stream
    startStream(40, 300);
    guard = 0;
    while (outIdx < inTotal && guard < 400) begin
      applyStimulus((guard % 2) == 0, 1'b0);
      guard++;
    end
    checkOutput("t4_count", 32'(outIdx), 32'd40);
    checkOutput("t4_peak_le_16", 32'(maxOutstanding <= FD), 32'd1);

    // clear with 5 tags in flight and 3 results buffered
    repeat (3) applyStimulus(1'b1, 1'b0);
    startStream(8, 500);
    repeat (10) applyStimulus(1'b0, 1'b0);
    checkOutput("t5_accepted", 32'(inIdx), 32'd8);
    checkOutput("t5_pre_mvalid", 32'(m_valid), 32'd1);
    checkOutput("t5_pre_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t5_clr_ce", 32'(mult_ce), 32'd0);
    checkOutput("t5_clr_sready", 32'(s_ready), 32'd0);
    startStream(4, 700);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_post_mvalid", 32'(m_valid), 32'd0);
    checkOutput("t5_post_busy", 32'(busy), 32'd0);
    guard = 0;
    while (outIdx < inTotal && guard < 60) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    repeat (3) applyStimulus(1'b1, 1'b0);
    checkOutput("t5_count", 32'(outIdx), 32'd4);
    checkOutput("t5_latency", 32'(firstValCyc - firstAccCyc), 32'd8);
    checkOutput("t5_mvalid_end", 32'(m_valid), 32'd0);

    // Three frames of four samples, then the counters
    startStream(12, 900);
    guard = 0;
    while (outIdx < inTotal && guard < 80) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_count", 32'(outIdx), 32'd12);
`ifdef GMM_VMM_CNT_EN
    expRes = 32'(popTotal);
    expFrm = 32'(frmTotal);
`else
    expRes = 32'd0;
    expFrm = 32'd0;
`endif
    checkOutput("t6_rescnt", res_cnt, expRes);
    checkOutput("t6_frmcnt", frm_cnt, expFrm);

    // Reset in the middle of a frame, then a fresh frame
    startStream(6, 1100);
    repeat (9) applyStimulus(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t7_rst_ce", 32'(mult_ce), 32'd0);
    checkOutput("t7_rst_mvalid", 32'(m_valid), 32'd0);
    checkOutput("t7_rst_busy", 32'(busy), 32'd0);
    checkOutput("t7_rst_rescnt", res_cnt, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    startStream(4, 1300);
    guard = 0;
    while (outIdx < inTotal && guard < 60) begin
      applyStimulus(1'b1, 1'b0);
      guard++;
    end
    checkOutput("t7_count", 32'(outIdx), 32'd4);
    checkOutput("t7_latency", 32'(firstValCyc - firstAccCyc), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
